// File: rtl/coin_pkg.sv
// coin_pkg: shared debounce state encodings and default parameter values for the coin path
package coin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_INSERTED = 2'd2,
        ST_RELEASE  = 2'd3
    } coin_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_MIN_GAP         = 2;
    localparam int DEF_PENDING_MAX     = 3;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronizes the raw coin sensor and turns each bouncy insertion into one coin_event
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_sense,
    output logic coin_event
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    coin_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s1_d, s2_q, s2_d;

    // state, debounce counter and synchronizer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    // next state: a level must persist DEBOUNCE_CYCLES synchronized cycles to be accepted
    always_comb begin
        s1_d    = coin_sense;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_CONFIRM;
                    cnt_d   = '0;
                end
            end
            ST_CONFIRM: begin
                if (!s2_q) state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_INSERTED;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_INSERTED: begin
                if (!s2_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (s2_q) state_d = ST_INSERTED;
                else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // event fires in the cycle the insertion is confirmed so the emitter sees it without extra delay
    always_comb begin
        coin_event = (state_q == ST_CONFIRM) && s2_q && (cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: buffers debounced coins and emits spaced one-cycle coin pulses, rejecting when full
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_GAP         = DEF_MIN_GAP,
    parameter int PENDING_MAX     = DEF_PENDING_MAX
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               coin_sense,
    input  logic                               hold,
    output logic                               coin_out,
    output logic                               reject_out,
    output logic [$clog2(PENDING_MAX+1)-1:0]   pending
);

    localparam int PW = $clog2(PENDING_MAX + 1);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [PW-1:0] PMAX     = PW'(PENDING_MAX);
    localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP);

    logic          coin_event, emit, full;
    logic          coin_out_q, coin_out_d, reject_q, reject_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [GW-1:0] gap_q, gap_d;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .coin_sense (coin_sense),
        .coin_event (coin_event)
    );

    // output, pending and gap registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_out_q <= 1'b0;
            reject_q   <= 1'b0;
            pending_q  <= '0;
            gap_q      <= '0;
        end else begin
            coin_out_q <= coin_out_d;
            reject_q   <= reject_d;
            pending_q  <= pending_d;
            gap_q      <= gap_d;
        end
    end

    // a simultaneous event and emit cancel out, so a full buffer only rejects when nothing drains
    always_comb begin
        full       = pending_q == PMAX;
        emit       = !coin_out_q && gap_q == '0 && pending_q != '0 && !hold;
        coin_out_d = emit;
        gap_d      = emit ? GAP_INIT : (gap_q != '0 ? gap_q - 1'b1 : gap_q);
        reject_d   = coin_event && !emit && full;
        pending_d  = (coin_event && !emit && !full) ? pending_q + 1'b1 :
                     (emit && !coin_event)          ? pending_q - 1'b1 : pending_q;
    end

    assign coin_out   = coin_out_q;
    assign reject_out = reject_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenario checks of the coin acceptor with default parameters
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset, coin_sense, hold;
    logic       coin_out, reject_out;
    logic [1:0] pending;
    int total = 0;
    int bad = 0;
    int npulse, nrej, pmax;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .MIN_GAP(2), .PENDING_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin_sense (coin_sense),
        .hold       (hold),
        .coin_out   (coin_out),
        .reject_out (reject_out),
        .pending    (pending)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (coin_out === 1'b1) npulse++;
        if (reject_out === 1'b1) nrej++;
        if (int'(pending) > pmax) pmax = int'(pending);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr();
        npulse = 0;
        nrej = 0;
        pmax = 0;
    endtask

    task automatic coin(input int hi, input int lo);
        coin_sense = 1'b1;
        run(hi);
        coin_sense = 1'b0;
        run(lo);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        coin_sense = 1'b0;
        hold = 1'b0;
        clr();
        run(3);
        total++; if (coin_out !== 1'b0) begin bad++; $display("FAIL reset_coin_out got=%b want=0", coin_out); end
        total++; if (reject_out !== 1'b0) begin bad++; $display("FAIL reset_reject got=%b want=0", reject_out); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        reset = 1'b0;
        run(3);
    endtask

    task automatic test_single();
        clr();
        coin_sense = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 6) begin
                total++; if (coin_out !== 1'b0) begin bad++; $display("FAIL single_early coin_out=%b want=0", coin_out); end
                total++; if (pending !== 2'd1) begin bad++; $display("FAIL single_buffered pending=%0d want=1", pending); end
            end
            if (k == 7) begin
                total++; if (coin_out !== 1'b1) begin bad++; $display("FAIL single_latency coin_out=%b want=1", coin_out); end
                total++; if (pending !== 2'd0) begin bad++; $display("FAIL single_drain pending=%0d want=0", pending); end
            end
            if (k == 8) begin
                total++; if (coin_out !== 1'b0) begin bad++; $display("FAIL single_width coin_out=%b want=0", coin_out); end
            end
        end
        coin_sense = 1'b0;
        run(20);
        total++; if (npulse != 1) begin bad++; $display("FAIL single_count pulses=%0d want=1", npulse); end
        total++; if (nrej != 0) begin bad++; $display("FAIL single_reject rejects=%0d want=0", nrej); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL single_end pending=%0d want=0", pending); end
    endtask

    task automatic test_glitch();
        clr();
        coin(2, 20);
        total++; if (npulse != 0) begin bad++; $display("FAIL glitch_pulse pulses=%0d want=0", npulse); end
        total++; if (nrej != 0) begin bad++; $display("FAIL glitch_reject rejects=%0d want=0", nrej); end
        total++; if (pmax != 0) begin bad++; $display("FAIL glitch_pending max=%0d want=0", pmax); end
    endtask

    task automatic test_bounce();
        clr();
        coin_sense = 1'b1; run(10);
        coin_sense = 1'b0; run(2);
        coin_sense = 1'b1; run(2);
        coin_sense = 1'b0; run(12);
        total++; if (npulse != 1) begin bad++; $display("FAIL bounce_count pulses=%0d want=1", npulse); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL bounce_pending pending=%0d want=0", pending); end
    endtask

    task automatic test_buffer_reject();
        int exp_co[7] = '{1, 0, 0, 1, 0, 0, 1};
        int exp_p[7] = '{2, 2, 2, 1, 1, 1, 0};
        clr();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coin(8, 10);
            total++; if (int'(pending) != (i < 3 ? i + 1 : 3)) begin bad++; $display("FAIL buffer_pending_%0d pending=%0d want=%0d", i, pending, (i < 3 ? i + 1 : 3)); end
        end
        total++; if (nrej != 1) begin bad++; $display("FAIL buffer_reject rejects=%0d want=1", nrej); end
        total++; if (npulse != 0) begin bad++; $display("FAIL buffer_held pulses=%0d want=0", npulse); end
        hold = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            total++; if (int'(coin_out) != exp_co[k]) begin bad++; $display("FAIL drain_coin_%0d coin_out=%b want=%0d", k, coin_out, exp_co[k]); end
            total++; if (int'(pending) != exp_p[k]) begin bad++; $display("FAIL drain_pending_%0d pending=%0d want=%0d", k, pending, exp_p[k]); end
        end
        run(10);
        total++; if (npulse != 3) begin bad++; $display("FAIL drain_count pulses=%0d want=3", npulse); end
    endtask

    task automatic test_simultaneous();
        clr();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) coin(8, 10);
        total++; if (pending !== 2'd3) begin bad++; $display("FAIL simul_full pending=%0d want=3", pending); end
        coin_sense = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 5) hold = 1'b0;
            if (k == 6) begin
                total++; if (coin_out !== 1'b1) begin bad++; $display("FAIL simul_emit coin_out=%b want=1", coin_out); end
                total++; if (pending !== 2'd3) begin bad++; $display("FAIL simul_pending pending=%0d want=3", pending); end
                total++; if (reject_out !== 1'b0) begin bad++; $display("FAIL simul_reject reject_out=%b want=0", reject_out); end
            end
            if (k == 7) begin
                total++; if (reject_out !== 1'b0) begin bad++; $display("FAIL simul_reject_late reject_out=%b want=0", reject_out); end
            end
        end
        coin_sense = 1'b0;
        run(20);
        total++; if (npulse != 4) begin bad++; $display("FAIL simul_count pulses=%0d want=4", npulse); end
        total++; if (nrej != 0) begin bad++; $display("FAIL simul_rejects rejects=%0d want=0", nrej); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL simul_end pending=%0d want=0", pending); end
    endtask

    task automatic test_reset_mid();
        clr();
        hold = 1'b1;
        coin(8, 10);
        coin(8, 10);
        total++; if (pending !== 2'd2) begin bad++; $display("FAIL mid_setup pending=%0d want=2", pending); end
        reset = 1'b1;
        #1;
        total++; if (coin_out !== 1'b0) begin bad++; $display("FAIL mid_coin_out coin_out=%b want=0", coin_out); end
        total++; if (reject_out !== 1'b0) begin bad++; $display("FAIL mid_reject reject_out=%b want=0", reject_out); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL mid_pending pending=%0d want=0", pending); end
        run(1);
        reset = 1'b0;
        hold = 1'b0;
        clr();
        run(20);
        total++; if (npulse != 0) begin bad++; $display("FAIL mid_quiet pulses=%0d want=0", npulse); end
        coin_sense = 1'b1;
        run(8);
        total++; if (coin_out !== 1'b1) begin bad++; $display("FAIL cut_setup coin_out=%b want=1", coin_out); end
        reset = 1'b1;
        #1;
        total++; if (coin_out !== 1'b0) begin bad++; $display("FAIL cut_pulse coin_out=%b want=0", coin_out); end
        run(2);
        reset = 1'b0;
        clr();
        run(10);
        coin_sense = 1'b0;
        run(10);
        total++; if (npulse != 1) begin bad++; $display("FAIL reset_held_coin pulses=%0d want=1", npulse); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_bounce();
        test_buffer_reject();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front end of the coin path. It takes the raw, asynchronous and bouncy coin sensor and emits clean one-cycle coin pulses, which drive the vending FSM's coin_in input.
- Debounces each physical insertion so it counts as exactly one coin.
- Buffers coins while the downstream FSM is busy.
- Rejects coins when the buffer is full.
- Guarantees a minimum low gap between pulses so that back-to-back coins are never merged into a multi-cycle level.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles coin_sense must hold a level for that level to be accepted (>=2)
MIN_GAP, 2, minimum low cycles on coin_out between two pulses (>=1)
PENDING_MAX, 3, maximum coins buffered (>=1)

Ports:
clk  in  1  single clock domain
reset  in  1  asynchronous, active-high; clears all state
coin_sense  in  1  raw coin sensor, asynchronous, active-high while a coin passes
hold  in  1  downstream busy; new coin_out pulses are suppressed while high
coin_out  out  1  one-cycle pulse per accepted coin; connects to the vending FSM's coin_in
reject_out  out  1  one-cycle pulse: coin accepted but buffer full, coin returned
pending  out  $clog2(PENDING_MAX+1)  coins currently buffered

Behaviour:
Reset and synchronizer:
- Reset (async) clears coin_out=0, reject_out=0, pending=0, gap counter=0, debounce counter=0, both sync flops=0, FSM=IDLE.
- coin_sense passes through a 2-flop synchronizer; s2 is the synchronized value.

Debounce FSM (states IDLE, CONFIRM, INSERTED, RELEASE; cnt is the debounce counter):
- IDLE: s2=1 -> CONFIRM, cnt<=0.
- CONFIRM, s2=0 -> IDLE. This is a glitch; no event.
- CONFIRM, s2=1 and cnt==DEBOUNCE_CYCLES-1 -> INSERTED and raise coin_event for one cycle. Otherwise cnt++.
- INSERTED: s2=0 -> RELEASE, cnt<=0.
- RELEASE, s2=1 -> INSERTED. This is release bounce; no new event.
- RELEASE, s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Exactly one coin_event per insertion, regardless of bounce on either edge.

Emitter:
- emit = !coin_out && gap==0 && pending>0 && !hold, evaluated at each edge.
- On emit: coin_out<=1, gap<=MIN_GAP.
- coin_out is high for exactly one cycle. hold is sampled only at the emit decision and never truncates a pulse already in flight.
- gap decrements each cycle while nonzero. Consecutive pulses are separated by exactly MIN_GAP low cycles when pending>0 and hold=0.

Pending counter:
- coin_event alone: pending++ if pending<PENDING_MAX. Otherwise reject_out<=1 for one cycle and pending is unchanged.
- emit alone: pending--.
- coin_event and emit in the same cycle: pending unchanged, no reject, even when pending==PENDING_MAX.
- pending never exceeds PENDING_MAX and never underflows.

Latency (hold=0, pending=0, gap=0):
- Let e0 be the first edge sampling coin_sense=1.
- coin_out is high after edge e0+DEBOUNCE_CYCLES+3, provided coin_sense stays high >= DEBOUNCE_CYCLES+2 cycles.
- reject_out is high after the edge at which the rejected coin_event occurs.

Reset mid-operation:
- Buffered coins are discarded and any in-flight pulse is cut immediately.
- If coin_sense is high when reset releases, the insertion is debounced and counted as a new coin.

Outputs are registered; no combinational path from an input to any output.

Decomposition:
- Shared package/include coin_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_CONFIRM=2'd1, ST_INSERTED=2'd2, ST_RELEASE=2'd3;
  - default parameter values.
- Sub-module coin_debounce holds the synchronizer and debounce FSM, with output coin_event.
- coin_acceptor holds the pending counter, emitter, gap counter and reject logic.

Test Plan (all with DEBOUNCE_CYCLES=4, MIN_GAP=2, PENDING_MAX=3):
1. Single coin, hold=0: coin_sense high 10 cycles then low -> exactly one coin_out pulse, high after e0+7; reject_out stays 0; pending returns to 0.
2. Glitch: coin_sense high 2 cycles then low 20 -> no coin_out, no reject_out, pending=0 throughout.
3. Release bounce: coin_sense high 10, low 2, high 2, low 12 -> exactly one coin_out pulse.
4. Buffer and reject: hold=1, insert 4 well-formed coins -> pending=1,2,3, then a reject_out single pulse on the 4th with pending staying 3. Then hold=0 -> three coin_out pulses separated by exactly 2 low cycles, pending 3->2->1->0.
5. Full with simultaneous events: pending=3, hold dropped so the first emit lands on the same edge as a 4th coin_event -> reject_out=0, pending stays 3 on that edge, then drains to 0 after 3 pulses.
6. Reset mid-operation: pending=2, hold=1, assert reset between clock edges -> coin_out=0, reject_out=0, pending=0 immediately. Release with hold=0 and coin_sense=0 -> no coin_out for 20 cycles.
